// File: rtl/control_unit.sv
// Multi-cycle RV instruction control FSM: IDLE -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK.
// Optional feature: define CU_ADDI_EN to decode addi with R-type timing.
module control_unit #(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic                cu_clk,
  input  logic                cu_rst,
  input  logic [31:0]         cu_instr,
  input  logic                cu_instr_valid,
  output logic                cu_instr_ready,
  output logic [4:0]          cu_rf_addr_a,
  output logic [4:0]          cu_rf_addr_b,
  output logic [4:0]          cu_rf_write_addr,
  output logic                cu_rf_write_en,
  output logic [WORDSIZE-1:0] cu_immediate,
  output logic                cu_mux_0_sel,
  output logic                cu_mux_1_sel,
  output logic                cu_mux_2_sel,
  output logic [2:0]          cu_alu_operation,
  output logic                cu_dm_write_en,
  output logic                cu_done,
  output logic                cu_illegal
);

  typedef enum logic [2:0] {StIdle, StDecode, StExecute, StMemory, StWriteback} state_e;
  typedef enum logic [1:0] {KindAlu, KindLoad, KindStore} kind_e;

  state_e r_state, w_state_next;
  kind_e  r_kind, w_kind;
  logic [31:0] r_instr;

  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;
  logic       w_is_load, w_is_store, w_is_rtype, w_is_addi, w_legal;
  logic [WORDSIZE-1:0] w_imm_i, w_imm_s;

  logic [4:0]          w_addr_a, w_addr_b, w_write_addr;
  logic [WORDSIZE-1:0] w_immediate;
  logic                w_mux_0, w_mux_1, w_mux_2;
  logic [2:0]          w_alu;
  logic                w_rf_we, w_dm_we, w_done, w_illegal;

  assign w_opcode = r_instr[6:0];
  assign w_funct3 = r_instr[14:12];
  assign w_funct7 = r_instr[31:25];
  assign w_imm_i  = {{(WORDSIZE-12){r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s  = {{(WORDSIZE-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};

  assign w_is_load  = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010 || w_funct3 == 3'b011);
  assign w_is_store = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010 || w_funct3 == 3'b011);
  assign w_is_rtype = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) &&
                      (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
`ifdef CU_ADDI_EN
  assign w_is_addi  = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
`else
  assign w_is_addi  = 1'b0;
`endif
  assign w_legal = w_is_load | w_is_store | w_is_rtype | w_is_addi;

  always_comb begin
    w_kind       = KindAlu;
    w_addr_a     = '0;
    w_addr_b     = '0;
    w_write_addr = '0;
    w_immediate  = '0;
    w_mux_0      = 1'b0;
    w_mux_1      = 1'b0;
    w_mux_2      = 1'b0;
    w_alu        = 3'b000;
    if (w_is_load) begin
      w_kind       = KindLoad;
      w_addr_a     = r_instr[19:15];
      w_write_addr = r_instr[11:7];
      w_immediate  = w_imm_i;
      w_mux_2      = 1'b1;
    end else if (w_is_store) begin
      // Store data travels on port A, base address on port B.
      w_kind      = KindStore;
      w_addr_a    = r_instr[24:20];
      w_addr_b    = r_instr[19:15];
      w_immediate = w_imm_s;
      w_mux_0     = 1'b1;
    end else if (w_is_rtype) begin
      w_addr_a     = r_instr[19:15];
      w_addr_b     = r_instr[24:20];
      w_write_addr = r_instr[11:7];
      w_mux_1      = 1'b1;
      w_alu        = w_funct7[5] ? 3'b001 : 3'b000;
    end else if (w_is_addi) begin
      w_addr_a     = r_instr[19:15];
      w_write_addr = r_instr[11:7];
      w_immediate  = w_imm_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rf_we      = 1'b0;
    w_dm_we      = 1'b0;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    unique case (r_state)
      StIdle:      if (cu_instr_valid) w_state_next = StDecode;
      StDecode: begin
        if (w_legal) begin
          w_state_next = StExecute;
        end else begin
          w_illegal    = 1'b1;
          w_state_next = StIdle;
        end
      end
      StExecute:   w_state_next = (r_kind == KindAlu) ? StWriteback : StMemory;
      StMemory: begin
        if (r_kind == KindStore) begin
          w_dm_we      = 1'b1;
          w_done       = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_state_next = StWriteback;
        end
      end
      StWriteback: begin
        w_rf_we      = (cu_rf_write_addr != 5'd0);
        w_done       = 1'b1;
        w_state_next = StIdle;
      end
      default:     w_state_next = StIdle;
    endcase
    // A reset aborts the instruction, so nothing may be strobed in the reset cycle itself.
    if (cu_rst) begin
      w_rf_we   = 1'b0;
      w_dm_we   = 1'b0;
      w_done    = 1'b0;
      w_illegal = 1'b0;
    end
  end

  always_ff @(posedge cu_clk) begin
    if (cu_rst) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge cu_clk) begin
    if (cu_rst) begin
      r_instr <= '0;
    end else if (r_state == StIdle && cu_instr_valid) begin
      r_instr <= cu_instr;
    end
  end

  always_ff @(posedge cu_clk) begin
    if (cu_rst) begin
      r_kind           <= KindAlu;
      cu_rf_addr_a     <= '0;
      cu_rf_addr_b     <= '0;
      cu_rf_write_addr <= '0;
      cu_immediate     <= '0;
      cu_mux_0_sel     <= 1'b0;
      cu_mux_1_sel     <= 1'b0;
      cu_mux_2_sel     <= 1'b0;
      cu_alu_operation <= '0;
    end else if (r_state == StDecode && w_legal) begin
      r_kind           <= w_kind;
      cu_rf_addr_a     <= w_addr_a;
      cu_rf_addr_b     <= w_addr_b;
      cu_rf_write_addr <= w_write_addr;
      cu_immediate     <= w_immediate;
      cu_mux_0_sel     <= w_mux_0;
      cu_mux_1_sel     <= w_mux_1;
      cu_mux_2_sel     <= w_mux_2;
      cu_alu_operation <= w_alu;
    end
  end

  assign cu_instr_ready = (r_state == StIdle);
  assign cu_rf_write_en = w_rf_we;
  assign cu_dm_write_en = w_dm_we;
  assign cu_done        = w_done;
  assign cu_illegal     = w_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: expectations queued at issue, compared at retirement.
module tb_control_unit;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  instr;
  logic         valid;
  logic         ready;
  logic [4:0]   addr_a, addr_b, waddr;
  logic         rf_we, dm_we, done, illegal;
  logic [W-1:0] imm;
  logic         m0, m1, m2;
  logic [2:0]   alu;

  control_unit #(.WORDSIZE(W)) dut (
    .cu_clk           (clk),
    .cu_rst           (rst),
    .cu_instr         (instr),
    .cu_instr_valid   (valid),
    .cu_instr_ready   (ready),
    .cu_rf_addr_a     (addr_a),
    .cu_rf_addr_b     (addr_b),
    .cu_rf_write_addr (waddr),
    .cu_rf_write_en   (rf_we),
    .cu_immediate     (imm),
    .cu_mux_0_sel     (m0),
    .cu_mux_1_sel     (m1),
    .cu_mux_2_sel     (m2),
    .cu_alu_operation (alu),
    .cu_dm_write_en   (dm_we),
    .cu_done          (done),
    .cu_illegal       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           done_c, rf_c, dm_c, ill_c;
    logic [4:0]   a, b, w;
    logic [63:0]  imm;
    logic         m0, m1, m2;
    logic [2:0]   alu;
    bit           chk_b, chk_w, chk_imm, chk_m2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  time  t1, t2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.done_c = 0; e.rf_c = 0; e.dm_c = 0; e.ill_c = 0;
    e.a = '0; e.b = '0; e.w = '0; e.imm = '0;
    e.m0 = 1'b0; e.m1 = 1'b0; e.m2 = 1'b0; e.alu = '0;
    e.chk_b = 1'b0; e.chk_w = 1'b0; e.chk_imm = 1'b0; e.chk_m2 = 1'b0;
    return e;
  endfunction

  // Issue one instruction, watch every cycle until ready returns, then score it.
  task automatic run(input logic [31:0] op, output time t_hs);
    int c, rdy_c, d_c, r_c, m_c, i_c, nd, nr, nm, ni;
    logic [4:0]  sa, sb_, sw;
    logic [63:0] simm;
    logic        s0, s1, s2;
    logic [2:0]  salu;
    exp_t        e;
    c = 0;
    while (!ready && c < 20) begin @(posedge clk); #1; c++; end
    check("ready_before_issue", {63'd0, ready}, 64'd1);
    instr = op; valid = 1'b1;
    @(posedge clk); t_hs = $time; #1;
    // Keep offering a different word while busy; it must be ignored.
    instr = 32'h40000033;
    rdy_c = 0; d_c = 0; r_c = 0; m_c = 0; i_c = 0; nd = 0; nr = 0; nm = 0; ni = 0;
    sa = '0; sb_ = '0; sw = '0; simm = '0; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; salu = '0;
    for (c = 1; c <= 12; c++) begin
      if (ready) begin rdy_c = c; valid = 1'b0; break; end
      if (rf_we)   begin nr++; if (r_c == 0) r_c = c; end
      if (dm_we)   begin nm++; if (m_c == 0) m_c = c; end
      if (illegal) begin ni++; if (i_c == 0) i_c = c; end
      if (done) begin
        nd++; if (d_c == 0) d_c = c;
        sa = addr_a; sb_ = addr_b; sw = waddr; simm = imm;
        s0 = m0; s1 = m1; s2 = m2; salu = alu;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check("ready_cycle", rdy_c, (e.ill_c != 0 ? e.ill_c : e.done_c) + 1);
    check("done_cycle", d_c, e.done_c);
    check("done_count", nd, (e.done_c != 0) ? 1 : 0);
    check("rf_we_cycle", r_c, e.rf_c);
    check("rf_we_count", nr, (e.rf_c != 0) ? 1 : 0);
    check("dm_we_cycle", m_c, e.dm_c);
    check("dm_we_count", nm, (e.dm_c != 0) ? 1 : 0);
    check("illegal_cycle", i_c, e.ill_c);
    check("illegal_count", ni, (e.ill_c != 0) ? 1 : 0);
    if (e.done_c != 0) begin
      check("addr_a", sa, e.a);
      if (e.chk_b)   check("addr_b", sb_, e.b);
      if (e.chk_w)   check("write_addr", sw, e.w);
      if (e.chk_imm) check("immediate", simm, e.imm);
      check("mux_0", s0, e.m0);
      check("mux_1", s1, e.m1);
      if (e.chk_m2)  check("mux_2", s2, e.m2);
      check("alu_op", salu, e.alu);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; valid = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_imm", imm, 64'd0);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_waddr", waddr, 0);
    check("rst_sels", {m0, m1, m2, alu}, 0);
    check("rst_strobes", {rf_we, dm_we, done, illegal}, 0);
    rst = 1'b0;

    // ld x2,5(x7)
    e = blank(); e.done_c = 4; e.rf_c = 4; e.a = 5'd7; e.w = 5'd2; e.imm = 64'h5;
    e.m2 = 1'b1; e.chk_w = 1; e.chk_imm = 1; e.chk_m2 = 1;
    sb.push_back(e); run(32'h0053B103, t1);

    // sd x4,23(x2)
    e = blank(); e.done_c = 3; e.dm_c = 3; e.a = 5'd4; e.b = 5'd2; e.imm = 64'h17;
    e.m0 = 1'b1; e.chk_b = 1; e.chk_imm = 1;
    sb.push_back(e); run(32'h00413BA3, t1);

    // add x1,x2,x0 then sub x1,x0,x2 back to back
    e = blank(); e.done_c = 3; e.rf_c = 3; e.a = 5'd2; e.b = 5'd0; e.w = 5'd1; e.m1 = 1'b1;
    e.chk_b = 1; e.chk_w = 1; e.chk_m2 = 1;
    sb.push_back(e); run(32'h000100B3, t1);
    e = blank(); e.done_c = 3; e.rf_c = 3; e.a = 5'd0; e.b = 5'd2; e.w = 5'd1; e.m1 = 1'b1;
    e.alu = 3'b001; e.chk_b = 1; e.chk_w = 1; e.chk_m2 = 1;
    sb.push_back(e); run(32'h402000B3, t2);
    check("b2b_handshake_gap", t2 - t1, 64'd40);

    // ld x3,-8(x1)
    e = blank(); e.done_c = 4; e.rf_c = 4; e.a = 5'd1; e.w = 5'd3;
    e.imm = 64'hFFFF_FFFF_FFFF_FFF8; e.m2 = 1'b1; e.chk_w = 1; e.chk_imm = 1; e.chk_m2 = 1;
    sb.push_back(e); run(32'hFF80B183, t1);

    // add x0,x1,x2: retires but never writes
    e = blank(); e.done_c = 3; e.a = 5'd1; e.b = 5'd2; e.w = 5'd0; e.m1 = 1'b1;
    e.chk_b = 1; e.chk_w = 1; e.chk_m2 = 1;
    sb.push_back(e); run(32'h00208033, t1);

    e = blank(); e.ill_c = 1;
    sb.push_back(e); run(32'h00000000, t1);
    // lh (funct3 001) is not a supported load width
    e = blank(); e.ill_c = 1;
    sb.push_back(e); run(32'h00539103, t1);

    // addi x1,x2,5
`ifdef CU_ADDI_EN
    e = blank(); e.done_c = 3; e.rf_c = 3; e.a = 5'd2; e.w = 5'd1; e.imm = 64'h5;
    e.chk_w = 1; e.chk_imm = 1; e.chk_m2 = 1;
`else
    e = blank(); e.ill_c = 1;
`endif
    sb.push_back(e); run(32'h00510093, t1);

    // Reset while a load sits in MEMORY
    instr = 32'h0053B103; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("rst_mem_strobes", {rf_we, dm_we, done, illegal}, 0);
    @(posedge clk); #1; rst = 1'b0;
    check("rst_mem_ready", ready, 1);
    check("rst_mem_rf_we", rf_we, 0);
    check("rst_mem_imm", imm, 64'd0);
    @(posedge clk); #1;
    check("rst_mem_after", {rf_we, done}, 0);

    // Reset arriving in the WRITEBACK cycle must suppress that cycle's strobes
    instr = 32'h000100B3; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("wb_reached", rf_we, 1);
    rst = 1'b1; #1;
    check("rst_wb_strobes", {rf_we, done}, 0);
    @(posedge clk); #1; rst = 1'b0;
    check("rst_wb_ready", ready, 1);

    // Recovery after reset
    e = blank(); e.done_c = 4; e.rf_c = 4; e.a = 5'd7; e.w = 5'd2; e.imm = 64'h5;
    e.m2 = 1'b1; e.chk_w = 1; e.chk_imm = 1; e.chk_m2 = 1;
    sb.push_back(e); run(32'h0053B103, t1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
